// File: rtl/updown_counter_pkg.sv
// Shared constants for the up/down counter: 7-segment glyph table and direction codes.
// Latency: n/a (constants only).
// Backpressure: none.
//
// SEG_LUT entries are written abcdefg with segment a in bit 6, so assigning an
// entry to a [0:6] port puts segment a on index 0.
package updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1111110,  // 0
    7'b0110000,  // 1
    7'b1101101,  // 2
    7'b1111001,  // 3
    7'b0110011,  // 4
    7'b1011011,  // 5
    7'b1011111,  // 6
    7'b1110000,  // 7
    7'b1111111,  // 8
    7'b1111011,  // 9
    7'b1110111,  // A
    7'b0011111,  // b
    7'b1001110,  // C
    7'b0111101,  // d
    7'b1001111,  // E
    7'b1000111   // F
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Hex digit to active-high 7-segment pattern via lookup table.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output always follows input.
//
// Ports:
//   a   : 4-bit value to display
//   seg : segments [0:6] = a..g, active-high
module hex_to_7seg
  import updown_counter_pkg::*;
(
  input  logic [3:0] a,
  output logic [0:6] seg
);

  assign seg = SEG_LUT[a];

endmodule

// File: rtl/updown_counter.sv
// Free-running up/down binary counter with terminal-count flag and hex 7-seg decode.
// Latency: q updates one clock after rst/updown are sampled; h and seg follow q combinationally.
// Backpressure: none; no enable, the counter steps on every clock outside reset.
//
// Ports:
//   c      : clock, rising edge
//   rst    : synchronous active-high reset, clears q
//   updown : 1 = count up, 0 = count down
//   q      : registered count
//   h      : high when the next edge wraps (up at all-ones, down at zero); ignores rst
//   seg    : 7-segment pattern of q[3:0], [0:6] = a..g, active-high
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             c,
  input  logic             rst,
  input  logic             updown,
  output logic [WIDTH-1:0] q,
  output logic             h,
  output logic [0:6]       seg
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Plain modular arithmetic gives the wrap in both directions for free.
  always_ff @(posedge c) begin
    if (rst) begin
      q <= '0;
    end else if (updown == DIR_UP) begin
      q <= q + ONE;
    end else begin
      q <= q - ONE;
    end
  end

  // Terminal count looks only at q and direction so it reflects where the
  // count will go if reset is not asserted.
  assign h = (updown == DIR_UP) ? (q == '1) : (q == '0);

  hex_to_7seg u_hex_to_7seg (
    .a   (q[3:0]),
    .seg (seg)
  );

endmodule

// File: tb/tb_updown_counter.sv
// Self-checking bench for updown_counter: four lock-step instances, scoreboard of expected counts.
// Stimulus pushes the count it expects after each edge; a negedge monitor pops and checks q, h, seg.
module tb_updown_counter;

  localparam int W = 4;

  logic c;
  logic rst;
  logic updown;

  logic [W-1:0] qv   [4];
  logic         hv   [4];
  logic [0:6]   segv [4];

  updown_counter #(.WIDTH(W)) u0 (.c(c), .rst(rst), .updown(updown), .q(qv[0]), .h(hv[0]), .seg(segv[0]));
  updown_counter #(.WIDTH(W)) u1 (.c(c), .rst(rst), .updown(updown), .q(qv[1]), .h(hv[1]), .seg(segv[1]));
  updown_counter #(.WIDTH(W)) u2 (.c(c), .rst(rst), .updown(updown), .q(qv[2]), .h(hv[2]), .seg(segv[2]));
  updown_counter #(.WIDTH(W)) u3 (.c(c), .rst(rst), .updown(updown), .q(qv[3]), .h(hv[3]), .seg(segv[3]));

  initial c = 1'b0;
  always #5 c = ~c;

  // Glyphs abcdefg, segment a in bit 6.
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'b1111110; glyph[1]  = 7'b0110000; glyph[2]  = 7'b1101101; glyph[3]  = 7'b1111001;
    glyph[4]  = 7'b0110011; glyph[5]  = 7'b1011011; glyph[6]  = 7'b1011111; glyph[7]  = 7'b1110000;
    glyph[8]  = 7'b1111111; glyph[9]  = 7'b1111011; glyph[10] = 7'b1110111; glyph[11] = 7'b0011111;
    glyph[12] = 7'b1001110; glyph[13] = 7'b0111101; glyph[14] = 7'b1001111; glyph[15] = 7'b1000111;
  end

  int checks   = 0;
  int failures = 0;

  int sb [$];     // expected count after each edge
  int mq    = 0;  // reference count as an ordinary integer
  bit known = 0;  // reference is meaningful only after the first reset edge

  // Drive one edge's worth of inputs, then record the count the edge should produce.
  task automatic step(input logic r, input logic u);
    rst    = r;
    updown = u;
    @(posedge c);
    if (r) begin
      mq    = 0;
      known = 1;
    end else if (known) begin
      mq = u ? (mq + 1) % 16 : (mq + 15) % 16;
    end
    if (known) sb.push_back(mq);
    #1;
  endtask

  task automatic run(input logic r, input logic u, input int n);
    for (int k = 0; k < n; k++) step(r, u);
  endtask

  // Monitor: mid-cycle, one popped expectation per completed edge.
  always @(negedge c) begin
    if (sb.size() > 0) begin
      int       e;
      bit       eh;
      logic [6:0] s;
      e  = sb.pop_front();
      // Wraps next edge: going up from the top value, or down from zero.
      eh = (updown && e == 15) || (!updown && e == 0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (qv[i] !== 4'(e)) begin
          failures++;
          $display("FAIL q[u%0d] t=%0t got=%0d want=%0d", i, $time, qv[i], e);
        end
        checks++;
        if (hv[i] !== eh) begin
          failures++;
          $display("FAIL h[u%0d] t=%0t q=%0d updown=%0b got=%0b want=%0b", i, $time, e, updown, hv[i], eh);
        end
        s = segv[i];
        checks++;
        if (s !== glyph[e]) begin
          failures++;
          $display("FAIL seg[u%0d] t=%0t q=%0d got=%b want=%b", i, $time, e, s, glyph[e]);
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    updown = 1'b1;

    // Reset held three edges counting up, then release and count through a full up wrap.
    run(1'b1, 1'b1, 3);
    run(1'b0, 1'b1, 20);

    // Down wrap from 2: 1, 0, 15, 14.
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 2);
    run(1'b0, 1'b0, 4);

    // Direction change mid-count at 12: down to 11, back up to 12, no hold cycle.
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 12);
    run(1'b0, 1'b0, 1);
    run(1'b0, 1'b1, 1);

    // Reset mid-count at 9: q holds 9 until the edge, then 0, then resumes.
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 9);
    run(1'b1, 1'b1, 1);
    run(1'b0, 1'b1, 3);

    // Reset while counting down: h must stay driven by direction alone.
    run(1'b0, 1'b0, 5);
    run(1'b1, 1'b0, 2);
    run(1'b0, 1'b0, 3);

    // Long up run then down run across several wraps (well beyond 500 ns).
    run(1'b0, 1'b1, 50);
    run(1'b0, 1'b0, 50);

    // Random direction with occasional reset.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(15) == 0), 1'($urandom_range(1)));
    end

    // Let the monitor drain the scoreboard, bounded.
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge c);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
